// File: rtl/narrow_to_wide_packer_buffer.sv
// narrow_to_wide_packer_buffer
// Packs RATIO consecutive narrow beats (lane 0 = least significant) into one
// wide word, stores wide words in a circular RAM and streams them out through
// a two-stage read path (registered RAM read, then output register).
// The count output covers every committed word not yet popped, wherever it is:
// in the RAM, in the read stage or in the output register.

module narrow_to_wide_packer_buffer #(
    parameter int WIDTH_IN  = 4,
    parameter int WIDTH_OUT = 16,
    parameter int DEPTH     = 256,
    parameter int ADDRWIDTH = 8,
    parameter     RAM_STYLE = "auto"
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH_IN-1:0]  in_data,
    input  logic                 in_valid,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic [WIDTH_OUT-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ADDRWIDTH:0]   count
);

    localparam int RATIO = WIDTH_OUT / WIDTH_IN;
    localparam int LANEW = (RATIO > 1) ? $clog2(RATIO) : 1;

    localparam logic [LANEW-1:0]     LAST_LANE = LANEW'(RATIO - 1);
    localparam logic [ADDRWIDTH-1:0] LAST_ADDR = ADDRWIDTH'(DEPTH - 1);
    localparam logic [ADDRWIDTH:0]   DEPTH_C   = (ADDRWIDTH + 1)'(DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [LANEW-1:0]     lane_q,      lane_d;
    logic [WIDTH_OUT-1:0] pack_q,      pack_d;
    logic [ADDRWIDTH-1:0] wr_ptr_q,    wr_ptr_d;
    logic [ADDRWIDTH-1:0] rd_ptr_q,    rd_ptr_d;
    logic [ADDRWIDTH:0]   ram_cnt_q,   ram_cnt_d;   // unread entries in the RAM
    logic [ADDRWIDTH:0]   count_q,     count_d;     // all committed, unpopped words
    logic                 in_ready_q,  in_ready_d;
    logic                 s1_valid_q,  s1_valid_d;  // read stage holds a word
    logic                 out_valid_q, out_valid_d;
    logic [WIDTH_OUT-1:0] out_data_q,  out_data_d;

    // Storage array and its registered read port (not reset: block RAM)
    (* ram_style = RAM_STYLE *)
    logic [WIDTH_OUT-1:0] mem [DEPTH];
    logic [WIDTH_OUT-1:0] ram_rd_data_q;

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    logic                 accept;
    logic                 commit;
    logic                 pop;
    logic                 s1_advance;
    logic                 rd_issue;
    logic [WIDTH_OUT-1:0] merged_word;

    assign accept     = in_valid && in_ready_q;
    assign commit     = accept && (in_last || (lane_q == LAST_LANE));
    assign pop        = out_valid_q && out_ready;
    // The read stage hands its word to the output register when that
    // register is empty or is being popped on this edge.
    assign s1_advance = s1_valid_q && (!out_valid_q || pop);
    // Only read when the RAM has unread data, so a read never targets the
    // slot being written; the read stage must be free or draining.
    assign rd_issue   = (ram_cnt_q != '0) && (!s1_valid_q || s1_advance);

    // ------------------------------------------------------------------
    // Lane merge: lanes below the current one come from the packing
    // register, the current lane takes in_data and lanes above are zero,
    // which also gives the zero fill on an early in_last close.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < RATIO; gi++) begin : g_lane
            assign merged_word[gi*WIDTH_IN +: WIDTH_IN] =
                (lane_q == LANEW'(gi)) ? in_data :
                ((LANEW'(gi) < lane_q) ? pack_q[gi*WIDTH_IN +: WIDTH_IN]
                                       : {WIDTH_IN{1'b0}});
        end
    endgenerate

    // Next-state computation for packer, pointers, occupancy and read path
    always_comb begin
        lane_d      = lane_q;
        pack_d      = pack_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        ram_cnt_d   = ram_cnt_q;
        count_d     = count_q;
        s1_valid_d  = s1_valid_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        // Packer: advance lane or close the word
        if (accept) begin
            if (commit) begin
                lane_d   = '0;
                pack_d   = '0;
                wr_ptr_d = (wr_ptr_q == LAST_ADDR) ? '0 : wr_ptr_q + 1'b1;
            end else begin
                lane_d = lane_q + 1'b1;
                pack_d = merged_word;
            end
        end

        // Read pointer walks with every issued RAM read
        if (rd_issue) begin
            rd_ptr_d = (rd_ptr_q == LAST_ADDR) ? '0 : rd_ptr_q + 1'b1;
        end

        // Unread RAM entries: +1 on write, -1 on read issue
        case ({commit, rd_issue})
            2'b10:   ram_cnt_d = ram_cnt_q + 1'b1;
            2'b01:   ram_cnt_d = ram_cnt_q - 1'b1;
            default: ram_cnt_d = ram_cnt_q;
        endcase

        // Total held words: +1 on commit, -1 on pop
        case ({commit, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // Read stage occupancy
        if (rd_issue) begin
            s1_valid_d = 1'b1;
        end else if (s1_advance) begin
            s1_valid_d = 1'b0;
        end

        // Output register: load from read stage, or empty on pop
        if (s1_advance) begin
            out_valid_d = 1'b1;
            out_data_d  = ram_rd_data_q;
        end else if (pop) begin
            out_valid_d = 1'b0;
        end
    end

    // Registered in_ready mirrors the occupancy that the next cycle will see
    assign in_ready_d = (count_d < DEPTH_C);

    // Control and output registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_q      <= '0;
            pack_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            ram_cnt_q   <= '0;
            count_q     <= '0;
            in_ready_q  <= 1'b0;
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            lane_q      <= lane_d;
            pack_q      <= pack_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            ram_cnt_q   <= ram_cnt_d;
            count_q     <= count_d;
            in_ready_q  <= in_ready_d;
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    // Buffer RAM: write the completed word, registered read at rd_ptr
    always_ff @(posedge clk) begin
        if (commit) begin
            mem[wr_ptr_q] <= merged_word;
        end
        if (rd_issue) begin
            ram_rd_data_q <= mem[rd_ptr_q];
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign count     = count_q;

endmodule

// File: tb/tb_narrow_to_wide_packer_buffer.sv
// Directed bench for narrow_to_wide_packer_buffer (RATIO=4, DEPTH=4).
module tb_narrow_to_wide_packer_buffer;

    localparam int WI    = 4;
    localparam int WO    = 16;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [WI-1:0] in_data;
    logic          in_valid;
    logic          in_last;
    logic          in_ready;
    logic [WO-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic [AW:0]   count;

    int n_checks = 0;
    int n_fail   = 0;

    narrow_to_wide_packer_buffer #(
        .WIDTH_IN (WI),
        .WIDTH_OUT(WO),
        .DEPTH    (DEPTH),
        .ADDRWIDTH(AW),
        .RAM_STYLE("auto")
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_last  (in_last),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .count    (count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until accepted (bounded)
    task automatic send(input logic [WI-1:0] d, input logic last);
        bit done = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        for (int i = 0; i < 200 && !done; i++) begin
            if (in_ready) done = 1;
            tick();
        end
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL send_timeout: beat %h accepted=%0d required=1", d, done);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Wait (bounded) for out_valid; no comparison here
    task automatic wait_out_valid(output bit ok);
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) begin
                ok = 1;
                return;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 0; in_last = 0; in_data = '0; out_ready = 0;
        tick(); tick();
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b need 0", in_ready); end
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b need 0", out_valid); end
        n_checks++;
        if (out_data !== 16'h0000) begin n_fail++; $display("FAIL reset_out_data: got %h need 0000", out_data); end
        n_checks++;
        if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d need 0", count); end
        rst = 1'b0;
        tick();
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready: got %b need 1", in_ready); end
        $display("reset done, in_ready=%b count=%0d", in_ready, count);
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        send(4'h1, 0); send(4'h2, 0); send(4'h3, 0); send(4'h4, 0);
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_lat0: out_valid got %b need 0", out_valid); end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_lat1: out_valid got %b need 0", out_valid); end
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h4321) begin
            n_fail++; $display("FAIL basic_lat2: valid=%b data=%h need valid=1 data=4321", out_valid, out_data);
        end
        n_checks++;
        if (count !== 3'd1) begin n_fail++; $display("FAIL basic_count1: got %0d need 1", count); end
        $display("basic word out %h", out_data);
        tick();
        n_checks++;
        if (count !== 3'd0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL basic_after_pop: count=%0d valid=%b need 0/0", count, out_valid);
        end
    endtask

    task automatic test_last();
        bit ok;
        out_ready = 1'b1;
        send(4'hA, 0); send(4'hB, 1);
        wait_out_valid(ok);
        n_checks++;
        if (!ok || out_data !== 16'h00BA) begin
            n_fail++; $display("FAIL last_early: valid=%b data=%h need 00BA", ok, out_data);
        end
        $display("in_last word out %h", out_data);
        tick();
        send(4'h5, 0); send(4'h6, 0); send(4'h7, 0); send(4'h8, 0);
        wait_out_valid(ok);
        n_checks++;
        if (!ok || out_data !== 16'h8765) begin
            n_fail++; $display("FAIL last_restart: valid=%b data=%h need 8765", ok, out_data);
        end
        $display("restart word out %h", out_data);
        tick(); tick();
        n_checks++;
        if (count !== 3'd0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL last_drain: count=%0d valid=%b need 0/0", count, out_valid);
        end
    endtask

    task automatic test_full();
        bit ok;
        logic [WO-1:0] exp_w [4] = '{16'h2222, 16'h3333, 16'h4444, 16'h5555};
        out_ready = 1'b0;
        for (int w = 1; w <= 4; w++)
            for (int k = 0; k < 4; k++) send(4'(w), 0);
        tick(); tick(); tick();
        n_checks++;
        if (count !== 3'd4 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL full_state: count=%0d in_ready=%b need 4/0", count, in_ready);
        end
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h1111) begin
            n_fail++; $display("FAIL full_head: valid=%b data=%h need 1/1111", out_valid, out_data);
        end
        // beats offered while full must be ignored
        in_valid = 1'b1; in_data = 4'hF;
        tick(); tick(); tick();
        in_valid = 1'b0;
        n_checks++;
        if (count !== 3'd4) begin n_fail++; $display("FAIL full_ignore: count=%0d need 4", count); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1 || count !== 3'd3 || out_data !== 16'h2222) begin
            n_fail++; $display("FAIL full_pop: in_ready=%b count=%0d data=%h need 1/3/2222", in_ready, count, out_data);
        end
        for (int k = 0; k < 4; k++) send(4'h5, 0);
        tick(); tick();
        n_checks++;
        if (count !== 3'd4) begin n_fail++; $display("FAIL full_refill: count=%0d need 4", count); end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_out_valid(ok);
            n_checks++;
            if (!ok || out_data !== exp_w[i]) begin
                n_fail++; $display("FAIL full_order[%0d]: valid=%b data=%h need %h", i, ok, out_data, exp_w[i]);
            end
            $display("full drain word %h", out_data);
            tick();
        end
        n_checks++;
        if (count !== 3'd0) begin n_fail++; $display("FAIL full_empty: count=%0d need 0", count); end
    endtask

    task automatic test_back_to_back();
        int got = 0;
        int cyc = 0;
        fork
            begin
                for (int j = 0; j < 16; j++)
                    for (int k = 0; k < 4; k++) send(4'(j + k), 0);
            end
            begin
                logic          pv, pr;
                logic [WO-1:0] pd, ew;
                while (got < 16 && cyc < 600) begin
                    out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                    pv = out_valid; pd = out_data; pr = out_ready;
                    tick();
                    cyc++;
                    if (pv && pr) begin
                        ew = {4'(got + 3), 4'(got + 2), 4'(got + 1), 4'(got)};
                        n_checks++;
                        if (pd !== ew) begin
                            n_fail++; $display("FAIL bp_word[%0d]: got %h need %h", got, pd, ew);
                        end
                        $display("bp pop %0d word %h", got, pd);
                        got++;
                    end else if (pv && !pr) begin
                        n_checks++;
                        if (out_valid !== 1'b1 || out_data !== pd) begin
                            n_fail++; $display("FAIL bp_hold: valid=%b data=%h need 1/%h", out_valid, out_data, pd);
                        end
                    end
                end
            end
        join
        out_ready = 1'b0;
        n_checks++;
        if (got != 16) begin n_fail++; $display("FAIL bp_total: got %0d words need 16", got); end
    endtask

    task automatic test_stream();
        logic [WO-1:0] words [12];
        int got = 0;
        for (int i = 0; i < 12; i++) words[i] = WO'($urandom);
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 12; i++)
                    for (int k = 0; k < 4; k++) send(words[i][k*4 +: 4], 0);
            end
            begin
                int  t = 0;
                bit  ok;
                while (count != 3'(DEPTH) && t < 200) begin tick(); t++; end
                tick(); tick();
                n_checks++;
                if (count !== 3'(DEPTH)) begin n_fail++; $display("FAIL stream_fill: count=%0d need %0d", count, DEPTH); end
                out_ready = 1'b1;
                // prefilled words must leave on consecutive edges
                for (int i = 0; i < DEPTH; i++) begin
                    n_checks++;
                    if (out_valid !== 1'b1 || out_data !== words[i]) begin
                        n_fail++; $display("FAIL stream_burst[%0d]: valid=%b data=%h need 1/%h", i, out_valid, out_data, words[i]);
                    end
                    $display("stream pop %0d word %h", i, out_data);
                    tick();
                    got++;
                end
                while (got < 12) begin
                    wait_out_valid(ok);
                    n_checks++;
                    if (!ok || out_data !== words[got]) begin
                        n_fail++; $display("FAIL stream_word[%0d]: valid=%b data=%h need %h", got, ok, out_data, words[got]);
                    end
                    $display("stream pop %0d word %h", got, out_data);
                    tick();
                    got++;
                    if (!ok) got = 12;
                end
            end
        join
        tick(); tick();
        n_checks++;
        if (count !== 3'd0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL stream_end: count=%0d valid=%b need 0/0", count, out_valid);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        bit ok;
        out_ready = 1'b0;
        send(4'h1, 0); send(4'h2, 0); send(4'h3, 0); send(4'h4, 0);
        send(4'h5, 0); send(4'h6, 0); send(4'h7, 0); send(4'h8, 0);
        send(4'hD, 0); send(4'hE, 0);
        tick(); tick(); tick();
        n_checks++;
        if (count !== 3'd2 || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL arst_pre: count=%0d valid=%b need 2/1", count, out_valid);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 16'h0000 || count !== 3'd0 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL arst_clear: valid=%b data=%h count=%0d in_ready=%b need 0/0000/0/0",
                               out_valid, out_data, count, in_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        tick();
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL arst_release: in_ready=%b need 1", in_ready); end
        out_ready = 1'b1;
        send(4'h9, 0); send(4'hA, 0); send(4'hB, 0); send(4'hC, 0);
        wait_out_valid(ok);
        n_checks++;
        if (!ok || out_data !== 16'hCBA9) begin
            n_fail++; $display("FAIL arst_first_word: valid=%b data=%h need CBA9", ok, out_data);
        end
        $display("post-reset word out %h", out_data);
        tick(); tick(); tick(); tick();
        n_checks++;
        if (out_valid !== 1'b0 || count !== 3'd0) begin
            n_fail++; $display("FAIL arst_no_stale: valid=%b count=%0d need 0/0", out_valid, count);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_last();
        test_full();
        test_back_to_back();
        test_stream();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
